// File: rtl/seq_csa_multiplier.sv
// Iterative radix-2 shift-add multiplier. Each RUN cycle performs one partial-product
// add through a carry-select adder, then shifts {acc,q} right by one bit.

module csa_block (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] sum0,
  output logic [3:0] sum1,
  output logic       c0,
  output logic       c1
);
  assign {c0, sum0} = {1'b0, a} + {1'b0, b};
  assign {c1, sum1} = {1'b0, a} + {1'b0, b} + 5'd1;
endmodule

module csa #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  localparam int NB = N / 4;

  logic [NB-1:0][3:0] s0, s1;
  logic [NB-1:0]      c0, c1;
  logic [NB:0]        c;

  assign c[0] = cin;

  // Both carry hypotheses are precomputed per nibble; only the select chain ripples.
  for (genvar i = 0; i < NB; i++) begin : g_blk
    csa_block u_blk (
      .a   (a[4*i +: 4]),
      .b   (b[4*i +: 4]),
      .sum0(s0[i]),
      .sum1(s1[i]),
      .c0  (c0[i]),
      .c1  (c1[i])
    );
    assign sum[4*i +: 4] = c[i] ? s1[i] : s0[i];
    assign c[i+1]        = c[i] ? c1[i] : c0[i];
  end

  assign cout = c[NB];
endmodule

module seq_csa_multiplier #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] product,
  output logic           busy,
  output logic           done
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  acc, q, m;
  logic [CW-1:0] cnt;
  logic          neg;
  logic          load;
  logic [N-1:0]  mag_a, mag_b, add_b, sum;
  logic          cout;

  assign load  = start && (state == IDLE || state == DONE);
  // Signed operands are reduced to magnitudes; -2^(N-1) maps to 2^(N-1), still valid unsigned.
  assign mag_a = (signed_mode && a[N-1]) ? (~a + 1'b1) : a;
  assign mag_b = (signed_mode && b[N-1]) ? (~b + 1'b1) : b;
  assign add_b = q[0] ? m : '0;

  csa #(.N(N)) u_csa (
    .a   (acc),
    .b   (add_b),
    .cin (1'b0),
    .sum (sum),
    .cout(cout)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      product <= '0;
      acc     <= '0;
      q       <= '0;
      m       <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        m   <= mag_a;
        q   <= mag_b;
        neg <= signed_mode & (a[N-1] ^ b[N-1]);
        acc <= '0;
        cnt <= CW'(N - 1);
      end else if (state == RUN) begin
        {acc, q} <= {cout, sum, q[N-1:1]};
        cnt      <= cnt - 1'b1;
      end
      if (state == FIX)
        product <= neg ? -{acc, q} : {acc, q};
    end
  end

  assign busy = (state == RUN) || (state == FIX);
  assign done = (state == DONE);
endmodule

// File: tb/tb_seq_csa_multiplier.sv
// Scoreboarded bench: an N=8 instance for directed corners, reset and back-to-back runs,
// and an N=32 instance for a randomized regression against plain 64-bit arithmetic.

module tb_seq_csa_multiplier;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic [63:0] prod;
    int          e;
  } exp_t;
  exp_t q8[$], q32[$];
  exp_t x8, x32;

  logic        start8 = 0, sm8 = 0, busy8, done8;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [15:0] prod8, last8;
  logic        start32 = 0, sm32 = 0, busy32, done32;
  logic [31:0] a32 = 0, b32 = 0;
  logic [63:0] prod32, last32;

  seq_csa_multiplier #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
    .product(prod8), .busy(busy8), .done(done8)
  );
  seq_csa_multiplier #(.N(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .signed_mode(sm32), .a(a32), .b(b32),
    .product(prod32), .busy(busy32), .done(done32)
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference: interpret operands as n-bit (un)signed integers and multiply modulo 2^(2n).
  function automatic logic [63:0] ref_mul(int n, bit sm, logic [31:0] a, logic [31:0] b);
    logic [63:0] xa = 64'(a), xb = 64'(b), r;
    if (sm && a[n-1]) xa = xa - (64'd1 << n);
    if (sm && b[n-1]) xb = xb - (64'd1 << n);
    r = xa * xb;
    if (n < 32) r = r & ((64'd1 << (2*n)) - 1);
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) last8 = '0;
    else begin
      if (done8) begin
        if (q8.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL done8_unexpected: got done=1 required no pending op");
        end else begin
          x8 = q8.pop_front();
          check("prod8", 64'(prod8), x8.prod);
          check("lat8", 64'(cyc - x8.e), 64'd9);
        end
      end else check("hold8", 64'(prod8), 64'(last8));
      last8 = prod8;
    end
  end

  always @(negedge clk) begin
    if (rst) last32 = '0;
    else begin
      if (done32) begin
        if (q32.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL done32_unexpected: got done=1 required no pending op");
        end else begin
          x32 = q32.pop_front();
          check("prod32", prod32, x32.prod);
          check("lat32", 64'(cyc - x32.e), 64'd33);
        end
      end else check("hold32", prod32, last32);
      last32 = prod32;
    end
  end

  task automatic wait_done8(output int bc);
    int t = 0;
    bc = 0;
    while (!done8 && t < 100) begin
      if (busy8) bc++;
      @(negedge clk);
      t++;
    end
    if (!done8) begin
      n_chk++; n_fail++;
      $display("FAIL timeout8: got no done required done within 100 cycles");
    end
  endtask

  task automatic op8(bit sm, logic [7:0] a, logic [7:0] b, logic [15:0] exp, output int bc);
    int t = 0;
    @(negedge clk);
    while (busy8 && t < 100) begin @(negedge clk); t++; end
    start8 = 1; sm8 = sm; a8 = a; b8 = b;
    q8.push_back('{64'(exp), cyc + 1});
    @(negedge clk);
    start8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
    wait_done8(bc);
  endtask

  typedef struct {bit sm; logic [7:0] a, b; logic [15:0] p;} vec_t;
  vec_t dirs[7] = '{
    '{0, 8'hFF, 8'hFF, 16'hFE01}, '{1, 8'hFD, 8'h05, 16'hFFF1}, '{1, 8'h80, 8'h80, 16'h4000},
    '{1, 8'h00, 8'hA5, 16'h0000}, '{0, 8'h00, 8'hA5, 16'h0000}, '{0, 8'h01, 8'h80, 16'h0080},
    '{1, 8'h01, 8'h80, 16'hFF80}};

  initial begin
    int bc, acc_n, t, issued;
    #1;
    check("rst_busy8", 64'(busy8), 0);
    check("rst_done8", 64'(done8), 0);
    check("rst_prod8", 64'(prod8), 0);
    check("rst_prod32", prod32, 0);
    repeat (2) @(negedge clk);
    rst = 0;

    foreach (dirs[i]) begin
      op8(dirs[i].sm, dirs[i].a, dirs[i].b, dirs[i].p, bc);
      if (i == 0) check("busy_cycles8", 64'(bc), 64'd9);
    end

    // Start held high: DONE re-loads directly; operands scrambled while busy.
    acc_n = 0; t = 0;
    while (acc_n < 3 && t < 100) begin
      if (!busy8) begin
        start8 = 1; a8 = 8'd7; b8 = 8'd6; sm8 = 0;
        q8.push_back('{64'd42, cyc + 1});
        acc_n++;
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
      end
      @(negedge clk);
      t++;
    end
    start8 = 0;
    wait_done8(bc);

    // Asynchronous reset in the fourth RUN cycle.
    @(negedge clk);
    start8 = 1; a8 = 8'd9; b8 = 8'd9; sm8 = 0;
    @(negedge clk);
    start8 = 0;
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    check("arst_busy8", 64'(busy8), 0);
    check("arst_done8", 64'(done8), 0);
    check("arst_prod8", 64'(prod8), 0);
    @(negedge clk);
    #2 rst = 0;
    op8(0, 8'd12, 8'd11, 16'h0084, bc);

    issued = 0; t = 0;
    while (issued < 1500 && t < 1500 * 40) begin
      @(negedge clk);
      t++;
      if (!busy32) begin
        a32 = pick(); b32 = pick(); sm32 = 1'($urandom); start32 = 1;
        q32.push_back('{ref_mul(32, sm32, a32, b32), cyc + 1});
        issued++;
      end else begin
        start32 = 0; a32 = $urandom; b32 = $urandom; sm32 = 1'($urandom);
      end
    end
    @(negedge clk);
    start32 = 0;
    t = 0;
    while (q32.size() != 0 && t < 100) begin @(negedge clk); t++; end
    if (q32.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain32: got %0d pending required 0", q32.size());
    end
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
